// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl
//   March C- memory BIST engine. It drives a synchronous single-port memory
//   with one operation per cycle, checks the read data one cycle after each
//   read is issued, and reports pass/fail and mismatch addresses to the
//   repair logic.
//
//   Elements (N = MEM_SIZE):
//     E0 up(w0)  E1 up(r0,w1)  E2 up(r1,w0)  E3 down(r0,w1)  E4 down(r1,w0)  E5 up(r0)
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   start             begin a test run (only accepted in IDLE or DONE)
//   mem_en/mem_we     memory enable / write strobe
//   mem_addr          memory address
//   mem_wdata         write data (all zeros or all ones)
//   mem_rdata         read data, valid the cycle after a read is issued
//   busy, done        run in progress / run complete (held until next start)
//   fail              sticky mismatch flag for the current run
//   err_valid         one-cycle pulse per mismatch, with err_addr
//   first_fail_addr   address of the first mismatch of the run
//   fail_count        saturating mismatch count
module mbist_march_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 256,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [CNT_WIDTH-1:0]  fail_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  elem_t                 elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ph_q, ph_d;

  logic                  mem_en_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  exp_a_q;

  logic                  rd_pend_q, exp_q;
  logic [ADDR_WIDTH-1:0] cmp_addr_q;

  logic                  busy_q, done_q, fail_q, err_valid_q;
  logic [ADDR_WIDTH-1:0] err_addr_q, first_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic elem_down, two_ops, at_end, last_ph;
  logic issue, clear, op_we, op_val, mism;

  // The counters always describe the op currently on the bus; the comb block
  // selects the following op, and the op decode is taken from the *_d values
  // so the bus registers are loaded in the same edge as the counters.
  always_comb begin
    elem_down = (elem_q == E3) || (elem_q == E4);
    two_ops   = !((elem_q == E0) || (elem_q == E5));
    at_end    = elem_down ? (addr_q == '0) : (addr_q == LAST_ADDR);
    last_ph   = two_ops ? ph_q : 1'b1;

    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    ph_d    = ph_q;
    issue   = 1'b0;
    clear   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          elem_d  = E0;
          addr_d  = '0;
          ph_d    = 1'b0;
          issue   = 1'b1;
          clear   = 1'b1;
        end
      end
      S_RUN: begin
        if (!last_ph) begin
          ph_d  = 1'b1;
          issue = 1'b1;
        end else if (!at_end) begin
          ph_d   = 1'b0;
          addr_d = elem_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          issue  = 1'b1;
        end else if (elem_q == E5) begin
          state_d = S_DRAIN;
        end else begin
          elem_d = elem_t'(elem_q + 3'd1);
          ph_d   = 1'b0;
          addr_d = ((elem_q == E2) || (elem_q == E3)) ? LAST_ADDR : '0;
          issue  = 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // E1..E4 read the background of the previous element then write its inverse.
    op_we  = 1'b0;
    op_val = 1'b0;
    unique case (elem_d)
      E0: begin
        op_we  = 1'b1;
        op_val = 1'b0;
      end
      E5: begin
        op_we  = 1'b0;
        op_val = 1'b0;
      end
      default: begin
        op_we  = ph_d;
        op_val = ((elem_d == E2) || (elem_d == E4)) ^ ph_d;
      end
    endcase

    mism = rd_pend_q && (mem_rdata != {DATA_WIDTH{exp_q}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      elem_q      <= E0;
      addr_q      <= '0;
      ph_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      exp_a_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      exp_q       <= 1'b0;
      cmp_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      first_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;

      mem_en_q    <= issue;
      mem_we_q    <= issue && op_we;
      mem_addr_q  <= issue ? addr_d : '0;
      mem_wdata_q <= (issue && op_we) ? {DATA_WIDTH{op_val}} : '0;
      exp_a_q     <= op_val;

      // Second stage: the memory returns data for the read now on the bus
      // during the next cycle, so expectation and address move along with it.
      rd_pend_q  <= mem_en_q && !mem_we_q;
      exp_q      <= exp_a_q;
      cmp_addr_q <= mem_addr_q;

      busy_q <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q <= (state_d == S_DONE);

      if (clear) begin
        fail_q      <= 1'b0;
        cnt_q       <= '0;
        first_q     <= '0;
        err_valid_q <= 1'b0;
        err_addr_q  <= '0;
      end else begin
        err_valid_q <= mism;
        if (mism) begin
          err_addr_q <= cmp_addr_q;
          fail_q     <= 1'b1;
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_ONE;
          if (!fail_q) first_q <= cmp_addr_q;
        end
      end
    end
  end

  assign mem_en          = mem_en_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign fail            = fail_q;
  assign err_valid       = err_valid_q;
  assign err_addr        = err_addr_q;
  assign first_fail_addr = first_q;
  assign fail_count      = cnt_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Scoreboard bench for mbist_march_ctrl with a behavioural memory that can
// inject a bit0 stuck-at-1 at one address or a stuck-at-0 on every bit.
module tb_mbist_march_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mem_en, mem_we, busy, done, fail, err_valid;
  logic [AW-1:0] mem_addr, err_addr, first_fail_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] fail_count;

  mbist_march_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_SIZE  (N),
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .done           (done),
    .fail           (fail),
    .err_valid      (err_valid),
    .err_addr       (err_addr),
    .first_fail_addr(first_fail_addr),
    .fail_count     (fail_count)
  );

  always #5 clk = ~clk;

  // fault_mode: 0 none, 1 bit0 stuck-at-1 at address 5, 2 all bits stuck-at-0
  int          fault_mode = 0;
  logic [DW-1:0] mem [N];
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else if (fault_mode == 2) mem_rdata <= '0;
      else if (fault_mode == 1 && mem_addr == 4'd5) mem_rdata <= mem[mem_addr] | 8'h01;
      else mem_rdata <= mem[mem_addr];
    end
  end

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int k; logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} op_t;
  typedef struct {int k; logic [AW-1:0] addr;} err_t;
  typedef struct {int k; logic f; logic [CW-1:0] cnt; logic [AW-1:0] first;} res_t;
  op_t  op_q [$];
  err_t err_q[$];
  res_t res_q[$];

  int total = 0;
  int bad = 0;
  int res_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a bus op, an error
  // pulse, or the rising edge of done.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    op_t  o;
    err_t e;
    res_t r;
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (mem_en) begin
        chk("op_expected", op_q.size() != 0, 1);
        if (op_q.size() != 0) begin
          o = op_q.pop_front();
          chk("op_cycle", cyc - base, o.k);
          chk("op_we", mem_we, o.we);
          chk("op_addr", mem_addr, o.addr);
          if (o.we) chk("op_wdata", mem_wdata, o.data);
        end
      end else begin
        chk("idle_bus", {mem_we, mem_addr, mem_wdata}, 0);
      end
      if (err_valid) begin
        chk("err_expected", err_q.size() != 0, 1);
        if (err_q.size() != 0) begin
          e = err_q.pop_front();
          chk("err_cycle", cyc - base, e.k);
          chk("err_addr", err_addr, e.addr);
        end
      end
      if (done && !prev_done) begin
        chk("res_expected", res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          chk("done_cycle", cyc - base, r.k);
          chk("done_busy", busy, 0);
          chk("fail", fail, r.f);
          chk("fail_count", fail_count, r.cnt);
          chk("first_fail_addr", first_fail_addr, r.first);
          chk("ops_left", op_q.size(), 0);
          chk("errs_left", err_q.size(), 0);
        end
        res_seen++;
      end
      prev_done = done;
    end
  end

  // Pulses start, then loads the scoreboard with the March C- op trace and
  // the mismatches the selected fault produces.
  task automatic launch();
    int k;
    int a;
    logic up, rd, v;
    logic [DW-1:0] got;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    base = cyc - 1;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_fail", fail, 0);
    chk("start_cnt", fail_count, 0);
    chk("start_first", first_fail_addr, 0);
    chk("start_err", {err_valid, err_addr}, 0);
    k = 1;
    for (int el = 0; el < 6; el++) begin
      up = !(el == 3 || el == 4);
      for (int i = 0; i < N; i++) begin
        a = up ? i : N - 1 - i;
        for (int p = 0; p < 2; p++) begin
          if (el == 0 && p == 1) break;
          if (el == 5 && p == 1) break;
          if (el == 0) begin rd = 1'b0; v = 1'b0; end
          else if (el == 5) begin rd = 1'b1; v = 1'b0; end
          else begin rd = (p == 0); v = ((el == 2) || (el == 4)) ^ (p == 1); end
          op_q.push_back('{k, !rd, AW'(a), {DW{v}}});
          if (rd) begin
            got = {DW{v}};
            if (fault_mode == 2) got = '0;
            else if (fault_mode == 1 && a == 5) got = got | 8'h01;
            if (got != {DW{v}}) err_q.push_back('{k + 2, AW'(a)});
          end
          k++;
        end
      end
    end
  endtask

  task automatic run_march(input int fm, input logic f, input int cnt, input int first,
                           input bit pulse_mid);
    int r0;
    fault_mode = fm;
    r0 = res_seen;
    launch();
    res_q.push_back('{10 * N + 2, f, CW'(cnt), AW'(first)});
    if (pulse_mid) begin
      repeat (30) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < 10 * N + 40 && res_seen == r0; i++) @(posedge clk);
    chk("done_timeout", res_seen != r0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", done, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {mem_en, mem_we, mem_addr, mem_wdata, busy, done, fail,
                        err_valid, err_addr, first_fail_addr, fail_count}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_done", {busy, done}, 0);

    run_march(0, 1'b0, 0, 0, 1'b1);   // fault-free, start pulsed mid-run
    run_march(1, 1'b1, 3, 5, 1'b0);   // bit0 stuck-at-1 at address 5
    run_march(0, 1'b0, 0, 0, 1'b0);   // restart from DONE clears results
    run_march(2, 1'b1, 15, 0, 1'b0);  // stuck-at-0: 32 mismatches saturate

    // Reset sampled at the end of cycle 20 of a run.
    fault_mode = 0;
    launch();
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs", {mem_en, mem_we, mem_addr, mem_wdata, busy, done, fail,
                          err_valid, err_addr, first_fail_addr, fail_count}, 0);
    op_q.delete();
    err_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_idle", {mem_en, busy, done}, 0);
    run_march(0, 1'b0, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
